pipelined_carry_adder: RTL and testbench

// - Parametrised, pipelined add/subtract unit. Successor to the 8-bit NAND carry chain.
// - Splits a WIDTH-bit operation into NUM_SEG = WIDTH/SEG_WIDTH segments.
// - Resolves one segment's NAND carry chain per clock and registers the carry between segments.
// - Sits between the register-file read stage and writeback.
// - Valid/ready handshakes on both sides, with full backpressure.

---
 rtl/pipelined_carry_adder_pkg.sv | 18 +
 rtl/pipelined_carry_adder_if.sv | 29 ++
 rtl/pipelined_carry_adder_seg_carry_unit.sv | 33 +++
 rtl/pipelined_carry_adder.sv | 120 ++++++++++++
 tb/tb_pipelined_carry_adder.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipelined_carry_adder_pkg.sv
// Shared helpers and stage control type for the segmented add/subtract pipeline.
package adder_pkg;

  function automatic int num_seg(input int width, input int seg_width);
    return width / seg_width;
  endfunction

  // Each carry bit costs two NAND levels (generate term, then propagate term).
  function automatic int nand_levels(input int seg_width);
    return 2 * seg_width;
  endfunction

  typedef struct packed {
    logic valid;
    logic carry;
  } stage_ctl_t;

endpackage

// File: rtl/pipelined_carry_adder_if.sv
// Operand/result handshake bundle; the slave modport is the adder side.
// flags {ovf, zero, neg} exists only when ADDER_FLAGS_EN is defined.
interface pipelined_carry_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef ADDER_FLAGS_EN
  logic [2:0]       flags;

  modport slave  (input  in_valid, a, b, sub, cin, out_ready,
                  output in_ready, out_valid, sum, cout, flags);
  modport master (output in_valid, a, b, sub, cin, out_ready,
                  input  in_ready, out_valid, sum, cout, flags);
`else
  modport slave  (input  in_valid, a, b, sub, cin, out_ready,
                  output in_ready, out_valid, sum, cout);
  modport master (output in_valid, a, b, sub, cin, out_ready,
                  input  in_ready, out_valid, sum, cout);
`endif
endinterface

// File: rtl/pipelined_carry_adder_seg_carry_unit.sv
// NAND-NAND ripple over one segment: c[i+1] = nand(g_n[i], nand(p[i], c[i])), c[0] = c_in.
// NAND_TIME is the per-level delay annotation (ns); this model is zero-delay.
module seg_carry_unit
  import adder_pkg::*;
#(
  parameter int SEG_WIDTH = 8,
  parameter int NAND_TIME = 7
) (
  input  logic [SEG_WIDTH-1:0] g_n,
  input  logic [SEG_WIDTH-1:0] p,
  input  logic                 c_in,
  output logic [SEG_WIDTH:0]   c
);

  localparam int CHAIN_DELAY = NAND_TIME * nand_levels(SEG_WIDTH);

  if (CHAIN_DELAY < 0) begin : g_delay_check
    $error("seg_carry_unit: NAND_TIME must be non-negative");
  end

  logic ripple;

  always_comb begin
    ripple = c_in;
    c      = '0;
    for (int i = 0; i < SEG_WIDTH; i++) begin
      c[i]   = ripple;
      ripple = ~(g_n[i] & ~(p[i] & ripple));
    end
    c[SEG_WIDTH] = ripple;
  end

endmodule

// File: rtl/pipelined_carry_adder.sv
// Segmented add/sub: one SEG_WIDTH carry chain per stage, NUM_SEG-cycle latency, 1 beat/cycle;
// out_valid & ~out_ready freezes every stage. ADDER_FLAGS_EN adds registered flags {ovf, zero, neg}.
module pipelined_carry_adder
  import adder_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int SEG_WIDTH = 8,
  parameter int NAND_TIME = 7
) (
  input logic                    clk,
  input logic                    rst,
  pipelined_carry_adder_if.slave bus
);

  localparam int NUM_SEG = num_seg(WIDTH, SEG_WIDTH);

  if (WIDTH % SEG_WIDTH != 0) begin : g_width_check
    $error("pipelined_carry_adder: WIDTH must be a multiple of SEG_WIDTH");
  end

  typedef struct packed {
    stage_ctl_t       ctl;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } stage_t;

  // stg[k] holds the operands and incoming carry for segment k.
  stage_t           stg [NUM_SEG];
  stage_t           nxt [NUM_SEG];
  stage_t           entry;
  logic             adv;
  logic             out_valid_q;
  logic             cout_q;
  logic [WIDTH-1:0] sum_q;

  assign adv           = ~out_valid_q | bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;

  always_comb begin
    entry.ctl.valid = bus.in_valid;
    entry.ctl.carry = bus.sub | bus.cin;
    entry.res       = '0;
    entry.a         = bus.a;
    entry.b         = bus.sub ? ~bus.b : bus.b;
  end

  for (genvar k = 0; k < NUM_SEG; k++) begin : g_stage
    logic [SEG_WIDTH-1:0] seg_a;
    logic [SEG_WIDTH-1:0] seg_b;
    logic [SEG_WIDTH-1:0] g_n;
    logic [SEG_WIDTH-1:0] p;
    logic [SEG_WIDTH:0]   c;
    logic [WIDTH-1:0]     res_d;

    assign seg_a = stg[k].a[k*SEG_WIDTH +: SEG_WIDTH];
    assign seg_b = stg[k].b[k*SEG_WIDTH +: SEG_WIDTH];
    assign g_n   = ~(seg_a & seg_b);
    assign p     = seg_a ^ seg_b;

    seg_carry_unit #(
      .SEG_WIDTH (SEG_WIDTH),
      .NAND_TIME (NAND_TIME)
    ) u_chain (
      .g_n  (g_n),
      .p    (p),
      .c_in (stg[k].ctl.carry),
      .c    (c)
    );

    always_comb begin
      res_d = stg[k].res;
      res_d[k*SEG_WIDTH +: SEG_WIDTH] = p ^ c[SEG_WIDTH-1:0];
    end

    assign nxt[k] = '{ctl: '{valid: stg[k].ctl.valid, carry: c[SEG_WIDTH]},
                      res: res_d, a: stg[k].a, b: stg[k].b};
  end

`ifdef ADDER_FLAGS_EN
  logic [2:0] flags_q;
  logic [2:0] flags_d;

  // b in the stage register is already post-inversion for subtract.
  assign flags_d[2] = (stg[NUM_SEG-1].a[WIDTH-1] == stg[NUM_SEG-1].b[WIDTH-1]) &
                      (nxt[NUM_SEG-1].res[WIDTH-1] != stg[NUM_SEG-1].a[WIDTH-1]);
  assign flags_d[1] = (nxt[NUM_SEG-1].res == '0);
  assign flags_d[0] = nxt[NUM_SEG-1].res[WIDTH-1];
  assign bus.flags  = flags_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_SEG; k++) begin
        stg[k] <= '0;
      end
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
`ifdef ADDER_FLAGS_EN
      flags_q     <= '0;
`endif
    end else if (adv) begin
      stg[0] <= entry;
      for (int k = 1; k < NUM_SEG; k++) begin
        stg[k] <= nxt[k-1];
      end
      out_valid_q <= nxt[NUM_SEG-1].ctl.valid;
      sum_q       <= nxt[NUM_SEG-1].res;
      cout_q      <= nxt[NUM_SEG-1].ctl.carry;
`ifdef ADDER_FLAGS_EN
      flags_q     <= flags_d;
`endif
    end
  end

endmodule

// File: tb/tb_pipelined_carry_adder.sv
// Bench for pipelined_carry_adder: directed vector table, stall/flush sequences, random scoreboard.
// Builds with or without ADDER_FLAGS_EN.
module tb_pipelined_carry_adder;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pipelined_carry_adder_if #(.WIDTH(32)) bus ();
  pipelined_carry_adder_if #(.WIDTH(16)) bus16 ();

  pipelined_carry_adder #(.WIDTH(32), .SEG_WIDTH(8), .NAND_TIME(7)) dut (
    .clk (clk), .rst (rst), .bus (bus)
  );

  pipelined_carry_adder #(.WIDTH(16), .SEG_WIDTH(4), .NAND_TIME(7)) dut16 (
    .clk (clk), .rst (rst), .bus (bus16)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain modulo arithmetic with flag definitions from the operand signs.
  typedef struct packed {
    logic [2:0]  flags;
    logic        cout;
    logic [31:0] sum;
  } res_t;

  function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic sub, input logic cin);
    logic [31:0] bo;
    logic [32:0] t;
    res_t        r;
    bo      = sub ? ~b : b;
    t       = {1'b0, a} + {1'b0, bo} + {32'd0, (sub ? 1'b1 : cin)};
    r.sum   = t[31:0];
    r.cout  = t[32];
    r.flags = {(a[31] == bo[31]) && (t[31] != a[31]), t[31:0] == 32'd0, t[31]};
    return r;
  endfunction

  res_t exp_q[$];
  res_t mon_e;
  int   rcv = 0;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("mon_unexpected_out", {63'd0, bus.out_valid}, 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          rcv++;
          check("mon_sum", {32'd0, bus.sum}, {32'd0, mon_e.sum});
          check("mon_cout", {63'd0, bus.cout}, {63'd0, mon_e.cout});
`ifdef ADDER_FLAGS_EN
          check("mon_flags", {61'd0, bus.flags}, {61'd0, mon_e.flags});
`endif
        end
      end
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back(model(bus.a, bus.b, bus.sub, bus.cin));
    end
  end

  typedef struct {
    logic        sel16;
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        cin;
    logic [31:0] sum;
    logic        cout;
    logic [2:0]  flags;
  } vec_t;

  vec_t vecs[8];
  vec_t flush_vec;

  task automatic run_vec(input vec_t v, input int idx);
    int          lat;
    logic        ov;
    logic [31:0] s;
    logic        co;
`ifdef ADDER_FLAGS_EN
    logic [2:0]  fl;
`endif
    @(posedge clk); #1;
    if (v.sel16) begin
      bus16.a = v.a[15:0]; bus16.b = v.b[15:0];
      bus16.sub = v.sub; bus16.cin = v.cin; bus16.in_valid = 1'b1;
    end else begin
      bus.a = v.a; bus.b = v.b; bus.sub = v.sub; bus.cin = v.cin; bus.in_valid = 1'b1;
    end
    @(posedge clk); #1;
    bus.in_valid   = 1'b0;
    bus16.in_valid = 1'b0;
    lat = 0;
    ov  = 1'b0;
    s   = '0;
    co  = 1'b0;
    while (!ov && lat < 12) begin
      @(posedge clk); #1;
      lat++;
      if (v.sel16) begin
        ov = bus16.out_valid; s = {16'd0, bus16.sum}; co = bus16.cout;
`ifdef ADDER_FLAGS_EN
        fl = bus16.flags;
`endif
      end else begin
        ov = bus.out_valid; s = bus.sum; co = bus.cout;
`ifdef ADDER_FLAGS_EN
        fl = bus.flags;
`endif
      end
    end
    check($sformatf("vec%0d_latency", idx), 64'(lat), 64'd4);
    check($sformatf("vec%0d_sum", idx), {32'd0, s}, {32'd0, v.sum});
    check($sformatf("vec%0d_cout", idx), {63'd0, co}, {63'd0, v.cout});
`ifdef ADDER_FLAGS_EN
    check($sformatf("vec%0d_flags", idx), {61'd0, fl}, {61'd0, v.flags});
`endif
    @(posedge clk); #1;
    check($sformatf("vec%0d_bubble_after", idx),
          {63'd0, (v.sel16 ? bus16.out_valid : bus.out_valid)}, 64'd0);
  endtask

  logic [31:0] sa[8];
  logic [31:0] sb[8];
  logic        ssub[8];
  logic        scin[8];
  logic [31:0] held;
  logic        acc;
  logic        stall;
  logic        pend;
  int          sent;
  int          rcv0;
  int          nrand;

  initial begin
    vecs[0] = '{1'b0, 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 3'b000};
    vecs[1] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 3'b010};
    vecs[2] = '{1'b0, 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 3'b001};
    vecs[3] = '{1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 3'b101};
    vecs[4] = '{1'b1, 32'h0000_7FFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_8000, 1'b0, 3'b101};
    vecs[5] = '{1'b1, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 3'b010};
    vecs[6] = '{1'b0, 32'h0000_0007, 32'h0000_0005, 1'b1, 1'b0, 32'h0000_0002, 1'b1, 3'b000};
    vecs[7] = '{1'b0, 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 3'b100};
    flush_vec = '{1'b0, 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 32'h0000_0003, 1'b0, 3'b000};

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.sub = 1'b0; bus.cin = 1'b0;
    bus.out_ready = 1'b1;
    bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0; bus16.sub = 1'b0; bus16.cin = 1'b0;
    bus16.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst_sum", {32'd0, bus.sum}, 64'd0);
    check("rst_cout", {63'd0, bus.cout}, 64'd0);
    check("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    check("rst_out_valid16", {63'd0, bus16.out_valid}, 64'd0);
`ifdef ADDER_FLAGS_EN
    check("rst_flags", {61'd0, bus.flags}, 64'd0);
`endif

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Eight back-to-back beats with a three-cycle output stall in the middle.
    for (int i = 0; i < 8; i++) begin
      sa[i] = $urandom; sb[i] = $urandom;
      ssub[i] = 1'($urandom_range(0, 1)); scin[i] = 1'($urandom_range(0, 1));
    end
    rcv0 = rcv;
    sent = 0;
    held = '0;
    @(posedge clk); #1;
    for (int cyc = 0; cyc < 60 && (sent < 8 || exp_q.size() > 0); cyc++) begin
      stall = (cyc >= 6 && cyc < 9);
      bus.out_ready = !stall;
      if (sent < 8) begin
        bus.a = sa[sent]; bus.b = sb[sent]; bus.sub = ssub[sent]; bus.cin = scin[sent];
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (stall) begin
        check("stall_in_ready", {63'd0, bus.in_ready}, 64'd0);
        check("stall_out_valid", {63'd0, bus.out_valid}, 64'd1);
        if (cyc == 6) held = bus.sum;
        else check("stall_sum_stable", {32'd0, bus.sum}, {32'd0, held});
      end else if (sent < 8) begin
        check("stream_in_ready", {63'd0, bus.in_ready}, 64'd1);
      end
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      if (acc) sent++;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    check("stream_beats_out", 64'(rcv - rcv0), 64'd8);
    check("stream_queue_empty", 64'(exp_q.size()), 64'd0);

    // Three beats in flight, then a one-cycle reset: nothing may emerge.
    for (int i = 0; i < 3; i++) begin
      bus.a = 32'(i + 10); bus.b = 32'(i); bus.sub = 1'b0; bus.cin = 1'b0;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("flush_no_out", {63'd0, bus.out_valid}, 64'd0);
      @(posedge clk); #1;
    end
    run_vec(flush_vec, 8);

    // Random traffic with random backpressure against the scoreboard.
    rcv0  = rcv;
    nrand = 0;
    pend  = 1'b0;
    for (int cyc = 0; cyc < 400 && nrand < 40; cyc++) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if (!pend && $urandom_range(0, 1) == 1) begin
        bus.a = $urandom; bus.b = $urandom;
        if ($urandom_range(0, 4) == 0) bus.a = 32'hFFFF_FFFF;
        bus.sub = 1'($urandom_range(0, 1)); bus.cin = 1'($urandom_range(0, 1));
        pend = 1'b1;
      end
      bus.in_valid = pend;
      #1;
      acc = pend && bus.in_ready;
      @(posedge clk); #1;
      if (acc) begin
        pend = 1'b0;
        nrand++;
      end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("rand_beats_out", 64'(rcv - rcv0), 64'd40);
    check("rand_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
